pixel_burst_packer: RTL

PIXEL_BURST_PACKER -- requirements
Module: pixel_burst_packer

---
 rtl/pixel_burst_packer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/pixel_burst_packer.sv
// Packs RGB565 pixels four to a 64-bit word, queues them and writes them to a frame buffer as bursts.
// Define PIXEL_PACKER_DOUBLE_BUFFER_EN to alternate frames between BASE_ADDR0 and BASE_ADDR1.
module pixel_burst_packer #(
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter logic [31:0] BASE_ADDR0 = 32'h1000_0000,
    parameter logic [31:0] BASE_ADDR1 = 32'h1010_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_pixel_data,
    input  logic        i_pixel_valid,
    input  logic        i_frame_done,
    output logic        o_burst_req,
    output logic [31:0] o_burst_addr,
    output logic [6:0]  o_burst_len,
    input  logic        i_burst_ack,
    output logic [63:0] o_wdata,
    output logic        o_wvalid,
    input  logic        i_wready,
    output logic        o_wlast,
    output logic [31:0] o_frame_base,
    output logic        o_overflow,
    output logic [1:0]  dbg_state
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    // Handshakes: a request is accepted on a cycle with o_burst_req and i_burst_ack both high;
    // a beat is transferred on a cycle with o_wvalid and i_wready both high. Neither side
    // may withdraw or change an offered request or beat until it is accepted.
    typedef enum logic [1:0] {IDLE, REQ, DATA, FLUSH} state_t;

    state_t          state, state_next;
    logic [1:0]      rst_sync;
    logic            rst_int_n;

    logic [1:0]      pix_cnt, cnt_next;
    logic [47:0]     pix_hold, hold_next;
    logic [63:0]     word_q, word_next;
    logic            word_vld, wvld_next;
    logic            mark_q, flush_pend, take_done, flush_ready;

    logic [63:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_idx, rd_idx;
    logic [CW-1:0]   count, count_next, pre_cnt;
    logic            full, push, pop;

    logic [31:0]     wr_ptr, active_base, next_base;
    logic [6:0]      beat_cnt, len_sel;
    logic            load_req;

    // Reset asserts immediately and releases two clock edges after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign take_done = i_frame_done && !flush_pend;

    always_comb begin
        hold_next = pix_hold;
        cnt_next  = pix_cnt;
        word_next = word_q;
        wvld_next = 1'b0;
        if (i_pixel_valid) begin
            case (pix_cnt)
                2'd0: hold_next[15:0]  = i_pixel_data;
                2'd1: hold_next[31:16] = i_pixel_data;
                2'd2: hold_next[47:32] = i_pixel_data;
                default: begin
                    word_next = {i_pixel_data, pix_hold};
                    wvld_next = 1'b1;
                    hold_next = '0;
                end
            endcase
            cnt_next = pix_cnt + 2'd1;
        end
        // Unused pixel slots are always zero, so the partial word is already padded.
        if (take_done && cnt_next != 2'd0) begin
            word_next = {16'h0000, hold_next};
            wvld_next = 1'b1;
            hold_next = '0;
            cnt_next  = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            pix_cnt    <= 2'd0;
            pix_hold   <= '0;
            word_q     <= '0;
            word_vld   <= 1'b0;
            mark_q     <= 1'b0;
            flush_pend <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            pix_cnt  <= cnt_next;
            pix_hold <= hold_next;
            word_q   <= word_next;
            word_vld <= wvld_next;
            mark_q   <= take_done;
            if (state == FLUSH)  flush_pend <= 1'b0;
            else if (take_done)  flush_pend <= 1'b1;
            if (word_vld && full) o_overflow <= 1'b1;
        end
    end

    assign full       = (count == CW'(FIFO_DEPTH));
    assign push       = word_vld && !full;
    assign pop        = o_wvalid && i_wready;
    assign count_next = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= word_q;
    end

    // pre_cnt counts the words still queued ahead of the flush point once the marker lands.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            count   <= '0;
            pre_cnt <= '0;
        end else begin
            if (push) wr_idx <= wr_idx + AW'(1);
            if (pop)  rd_idx <= rd_idx + AW'(1);
            count <= count_next;
            if (mark_q)                      pre_cnt <= count_next;
            else if (pop && pre_cnt != '0)   pre_cnt <= pre_cnt - CW'(1);
        end
    end

    assign flush_ready = flush_pend && !mark_q;

    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        len_sel    = 7'(BURST_LEN);
        case (state)
            IDLE: begin
                if (flush_ready) begin
                    if (pre_cnt >= CW'(BURST_LEN)) begin
                        state_next = REQ;
                        load_req   = 1'b1;
                    end else if (pre_cnt != '0) begin
                        state_next = REQ;
                        load_req   = 1'b1;
                        len_sel    = 7'(pre_cnt);
                    end else begin
                        state_next = FLUSH;
                    end
                end else if (count >= CW'(BURST_LEN)) begin
                    state_next = REQ;
                    load_req   = 1'b1;
                end
            end
            REQ:     if (i_burst_ack) state_next = DATA;
            DATA:    if (pop && o_wlast) state_next = IDLE;
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef PIXEL_PACKER_DOUBLE_BUFFER_EN
    logic buf_sel;
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n)          buf_sel <= 1'b0;
        else if (state == FLUSH) buf_sel <= ~buf_sel;
    end
    assign active_base = buf_sel ? BASE_ADDR1 : BASE_ADDR0;
    assign next_base   = buf_sel ? BASE_ADDR0 : BASE_ADDR1;
`else
    logic unused_base1;
    assign unused_base1 = ^BASE_ADDR1;
    assign active_base  = BASE_ADDR0;
    assign next_base    = BASE_ADDR0;
`endif

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state        <= IDLE;
            o_burst_addr <= BASE_ADDR0;
            o_burst_len  <= 7'd0;
            wr_ptr       <= BASE_ADDR0;
            o_frame_base <= BASE_ADDR0;
            beat_cnt     <= 7'd0;
        end else begin
            state <= state_next;
            if (load_req) begin
                o_burst_addr <= wr_ptr;
                o_burst_len  <= len_sel;
            end
            if (state == REQ && i_burst_ack) wr_ptr <= wr_ptr + 32'({o_burst_len, 3'b000});
            if (state == REQ) beat_cnt <= 7'd0;
            else if (pop)     beat_cnt <= beat_cnt + 7'd1;
            if (state == FLUSH) begin
                o_frame_base <= active_base;
                wr_ptr       <= next_base;
            end
        end
    end

    assign o_burst_req = (state == REQ);
    assign o_wvalid    = (state == DATA) && (count != '0);
    assign o_wlast     = o_wvalid && (beat_cnt == o_burst_len - 7'd1);
    assign o_wdata     = o_wvalid ? mem[rd_idx] : 64'd0;
    assign dbg_state   = state;

endmodule
